// File: rtl/spike_rate_meter_if.sv
// spike_rate_meter_if: control inputs and measurement results of the spike rate meter
interface spike_rate_meter_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8,
  parameter int ISI_W = 12
);
  logic             ena;
  logic             clear;
  logic             spike;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_sat;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;
  logic             busy;
  modport master (
    output ena, clear, spike, win_len,
    input  rate, rate_valid, rate_sat, isi, isi_valid, busy
  );
  modport slave (
    input  ena, clear, spike, win_len,
    output rate, rate_valid, rate_sat, isi, isi_valid, busy
  );
endinterface

// File: rtl/spike_rate_meter.sv
// spike_rate_meter: windowed spike-edge rate counter with inter-spike interval measurement
module spike_rate_meter #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8,
  parameter int ISI_W = 12
) (
  input logic clk,
  input logic rst_n,
  spike_rate_meter_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic             spike_d;
  logic [WIN_W-1:0] win_cnt, win_n, n_load;
  logic [CNT_W-1:0] acc, acc_nxt, rate_q;
  logic             sat, sat_nxt, rate_sat_q, rate_valid_q;
  logic [ISI_W-1:0] isi_cnt, isi_q;
  logic             seen, isi_valid_q;
  logic             ev, last;
  assign bus.rate       = rate_q;
  assign bus.rate_sat   = rate_sat_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.isi        = isi_q;
  assign bus.isi_valid  = isi_valid_q;
  assign bus.busy       = (state == RUN);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // next state, edge detect, window end and saturating accumulate
  always_comb begin
    state_nxt = bus.clear ? IDLE : (bus.ena ? RUN : IDLE);
    ev        = bus.spike & ~spike_d;
    last      = (state == RUN) && (win_cnt == win_n - 1'b1);
    acc_nxt   = (ev && !(&acc)) ? acc + 1'b1 : acc;
    sat_nxt   = sat | (ev & (&acc));
    n_load    = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
  end
  // window counting, rate publication and interval measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d      <= 1'b0;
      win_cnt      <= '0;
      win_n        <= '0;
      acc          <= '0;
      sat          <= 1'b0;
      rate_q       <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_cnt      <= '0;
      seen         <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      spike_d      <= bus.spike;
      rate_valid_q <= 1'b0;
      isi_valid_q  <= 1'b0;
      if (bus.clear) begin
        win_cnt    <= '0;
        win_n      <= '0;
        acc        <= '0;
        sat        <= 1'b0;
        rate_q     <= '0;
        rate_sat_q <= 1'b0;
        isi_cnt    <= '0;
        seen       <= 1'b0;
        isi_q      <= '0;
      end else begin
        if (state == IDLE) begin
          acc     <= '0;
          sat     <= 1'b0;
          win_cnt <= '0;
          if (bus.ena) win_n <= n_load;
        end else if (last) begin
          rate_q       <= acc_nxt;
          rate_sat_q   <= sat_nxt;
          rate_valid_q <= 1'b1;
          acc          <= '0;
          sat          <= 1'b0;
          win_cnt      <= '0;
          win_n        <= n_load;
        end else if (!bus.ena) begin
          acc     <= '0;
          sat     <= 1'b0;
          win_cnt <= '0;
        end else begin
          acc     <= acc_nxt;
          sat     <= sat_nxt;
          win_cnt <= win_cnt + 1'b1;
        end
        if (!bus.ena) begin
          seen    <= 1'b0;
          isi_cnt <= '0;
        end else if (ev) begin
          isi_cnt <= ISI_W'(1);
          seen    <= 1'b1;
          if (seen) begin
            isi_q       <= isi_cnt;
            isi_valid_q <= 1'b1;
          end
        end else if (seen && !(&isi_cnt)) begin
          isi_cnt <= isi_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_meter.sv
// tb_spike_rate_meter: directed checks of window rate, saturation, ISI, abort, clear and reset
module tb_spike_rate_meter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  spike_rate_meter_if #(.WIN_W(16), .CNT_W(8), .ISI_W(12)) b0 ();
  spike_rate_meter_if #(.WIN_W(16), .CNT_W(4), .ISI_W(4)) b1 ();
  spike_rate_meter #(.WIN_W(16), .CNT_W(8), .ISI_W(12)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  spike_rate_meter #(.WIN_W(16), .CNT_W(4), .ISI_W(4)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_cycle(input logic s);
    b0.spike = s;
    tick();
  endtask
  task automatic win10(input logic [9:0] pat, input int exp_rate);
    for (int i = 0; i < 10; i++) begin
      run_cycle(pat[i]);
      if (i < 9) chk("rate_valid_mid", int'(b0.rate_valid), 0);
    end
    chk("rate_valid_end", int'(b0.rate_valid), 1);
    chk("rate", int'(b0.rate), exp_rate);
    chk("busy_run", int'(b0.busy), 1);
  endtask
  initial begin
    b0.ena = 0; b0.clear = 0; b0.spike = 0; b0.win_len = 16'd10;
    b1.ena = 0; b1.clear = 0; b1.spike = 0; b1.win_len = 16'd40;
    tick(); tick();
    chk("rst_rate", int'(b0.rate), 0);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_isi", int'(b0.isi), 0);
    chk("rst_valids", int'({b0.rate_valid, b0.isi_valid}), 0);
    rst_n = 1'b1;
    tick();
    b0.ena = 1;
    run_cycle(0);
    chk("busy_start", int'(b0.busy), 1);
    win10(10'b1000001001, 3);
    chk("rate_sat0", int'(b0.rate_sat), 0);
    chk("isi_w1", int'(b0.isi), 6);
    chk("isi_valid_w1", int'(b0.isi_valid), 1);
    win10(10'b1101111110, 2);
    chk("isi_w2", int'(b0.isi), 7);
    chk("isi_valid_w2", int'(b0.isi_valid), 0);
    win10(10'b0000100101, 2);
    chk("isi_w3", int'(b0.isi), 3);
    for (int i = 0; i < 5; i++) run_cycle(i == 1);
    b0.ena = 0;
    run_cycle(0);
    chk("abort_busy", int'(b0.busy), 0);
    chk("abort_valid", int'(b0.rate_valid), 0);
    chk("abort_rate", int'(b0.rate), 2);
    chk("abort_isi", int'(b0.isi), 6);
    for (int i = 0; i < 6; i++) run_cycle(0);
    chk("abort_valid_late", int'(b0.rate_valid), 0);
    b0.win_len = 16'd1000;
    b0.ena = 1;
    run_cycle(0);
    run_cycle(1);
    chk("isi_first_valid", int'(b0.isi_valid), 0);
    chk("isi_first_hold", int'(b0.isi), 6);
    for (int i = 0; i < 36; i++) run_cycle(0);
    chk("isi_gap_valid", int'(b0.isi_valid), 0);
    run_cycle(1);
    chk("isi37_valid", int'(b0.isi_valid), 1);
    chk("isi37", int'(b0.isi), 37);
    run_cycle(0);
    chk("isi_pulse", int'(b0.isi_valid), 0);
    b0.ena = 0;
    run_cycle(0);
    chk("idle_busy", int'(b0.busy), 0);
    b0.ena = 1;
    b0.win_len = 16'd0;
    run_cycle(0);
    run_cycle(1);
    chk("w0_valid_a", int'(b0.rate_valid), 1);
    chk("w0_rate_a", int'(b0.rate), 1);
    run_cycle(0);
    chk("w0_valid_b", int'(b0.rate_valid), 1);
    chk("w0_rate_b", int'(b0.rate), 0);
    run_cycle(1);
    chk("w0_rate_c", int'(b0.rate), 1);
    b0.clear = 1;
    run_cycle(0);
    chk("clr_rate", int'(b0.rate), 0);
    chk("clr_isi", int'(b0.isi), 0);
    chk("clr_busy", int'(b0.busy), 0);
    chk("clr_valids", int'({b0.rate_valid, b0.isi_valid, b0.rate_sat}), 0);
    b0.clear = 0;
    run_cycle(0);
    chk("clr_restart", int'(b0.busy), 1);
    b1.ena = 1;
    tick();
    for (int i = 0; i < 40; i++) begin
      b1.spike = (i % 2 == 0);
      tick();
    end
    chk("sat_valid", int'(b1.rate_valid), 1);
    chk("sat_rate", int'(b1.rate), 15);
    chk("sat_flag", int'(b1.rate_sat), 1);
    chk("sat_isi", int'(b1.isi), 2);
    for (int i = 0; i < 40; i++) begin
      b1.spike = (i == 38);
      tick();
      if (i == 38) begin
        chk("isi_sat_valid", int'(b1.isi_valid), 1);
        chk("isi_sat", int'(b1.isi), 15);
      end
    end
    chk("w2_rate", int'(b1.rate), 1);
    chk("w2_sat", int'(b1.rate_sat), 0);
    chk("pre_rst_busy", int'(b1.busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rate", int'(b1.rate), 0);
    chk("async_isi", int'(b1.isi), 0);
    chk("async_busy", int'(b1.busy), 0);
    b0.ena = 0;
    b1.ena = 0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", int'(b1.busy), 0);
    b1.ena = 1;
    tick();
    chk("post_rst_run", int'(b1.busy), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
